// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : State encoding and default timing constants for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam logic [2:0] c_st_arb       = 3'd0;
    localparam logic [2:0] c_st_start     = 3'd1;
    localparam logic [2:0] c_st_wait_busy = 3'd2;
    localparam logic [2:0] c_st_wait_idle = 3'd3;
    localparam logic [2:0] c_st_gap       = 3'd4;

    typedef enum logic [2:0] {
        ARB       = c_st_arb,
        START     = c_st_start,
        WAIT_BUSY = c_st_wait_busy,
        WAIT_IDLE = c_st_wait_idle,
        GAP       = c_st_gap
    } arb_state_e;

    localparam int c_busy_timeout = 15;
    localparam int c_gap_cycles   = 16;

    // One shared counter serves both the busy timeout and the post-packet gap.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester bundle plus UART transmit-side signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int BAUD_WIDTH = 20
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [8*NUM_REQ-1:0]          req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [BAUD_WIDTH*NUM_REQ-1:0] req_baud;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          tx_start;
    logic [7:0]                    tx_data;
    logic [BAUD_WIDTH-1:0]         baud_var;
    logic                          tx_idle;
    logic                          busy;
    logic                          err_timeout;

    modport master (
        input  req_valid, req_data, req_last, req_baud, tx_idle,
        output req_ready, grant, tx_start, tx_data, baud_var, busy, err_timeout
    );

    modport slave (
        output req_valid, req_data, req_last, req_baud, tx_idle,
        input  req_ready, grant, tx_start, tx_data, baud_var, busy, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational select of the first set request at or after a pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_ptr,
    output logic                    o_any,
    output logic [NUM_REQ-1:0]      o_onehot,
    output logic [IDX_W-1:0]        o_idx
);
    localparam int SW = IDX_W + 1;

    logic [SW-1:0]    w_sum;
    logic [IDX_W-1:0] w_j;

    // Scan farthest offset first so the nearest hit overwrites earlier ones.
    always_comb begin
        o_any    = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        w_sum    = '0;
        w_j      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_ptr} + SW'(i);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            w_j = w_sum[IDX_W-1:0];
            if (i_req[w_j]) begin
                o_any         = 1'b1;
                o_onehot      = '0;
                o_onehot[w_j] = 1'b1;
                o_idx         = w_j;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-locked round-robin sharing of one UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BAUD_WIDTH   = 20,
    parameter int GAP_CYCLES   = c_gap_cycles,
    parameter int BUSY_TIMEOUT = c_busy_timeout
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_tx_arbiter_if.master  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(GAP_CYCLES, BUSY_TIMEOUT);

    arb_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [BAUD_WIDTH-1:0]  baud_q, baud_d;
    logic [7:0]             data_q, data_d;
    logic                   tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic                   last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic [7:0]             w_data [NUM_REQ];
    logic [BAUD_WIDTH-1:0]  w_baud [NUM_REQ];
    logic                   w_any;
    logic [NUM_REQ-1:0]     w_onehot;
    logic [IDX_W-1:0]       w_idx;
    logic [IDX_W-1:0]       w_ptr_next;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_data[gi] = bus.req_data[8*gi +: 8];
        assign w_baud[gi] = bus.req_baud[BAUD_WIDTH*gi +: BAUD_WIDTH];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .i_req    (bus.req_valid),
        .i_ptr    (ptr_q),
        .o_any    (w_any),
        .o_onehot (w_onehot),
        .o_idx    (w_idx)
    );

    assign w_ptr_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        baud_d     = baud_q;
        data_d     = data_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        ready_d    = '0;
        err_d      = 1'b0;
        case (state_q)
            ARB: begin
                grant_d = '0;
                if (w_any && bus.tx_idle) begin
                    baud_d  = w_baud[w_idx];
                    grant_d = w_onehot;
                    idx_d   = w_idx;
                    state_d = START;
                end
            end
            START: begin
                // A stalled owner keeps the lock; nobody else is looked at here.
                if (bus.req_valid[idx_q]) begin
                    data_d     = w_data[idx_q];
                    tx_start_d = 1'b1;
                    ready_d    = grant_q;
                    last_d     = bus.req_last[idx_q];
                    cnt_d      = '0;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!bus.tx_idle) begin
                    state_d = WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(BUSY_TIMEOUT)) begin
                        err_d   = 1'b1;
                        grant_d = '0;
                        ptr_d   = w_ptr_next;
                        cnt_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            WAIT_IDLE: begin
                if (bus.tx_idle) begin
                    if (last_q) begin
                        grant_d = '0;
                        cnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        state_d = START;
                    end
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    ptr_d   = w_ptr_next;
                    cnt_d   = '0;
                    state_d = ARB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            grant_q    <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            baud_q     <= '0;
            data_q     <= '0;
            tx_start_q <= 1'b0;
            ready_q    <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            baud_q     <= baud_d;
            data_q     <= data_d;
            tx_start_q <= tx_start_d;
            ready_q    <= ready_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.grant       = grant_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = data_q;
    assign bus.baud_var    = baud_q;
    assign bus.busy        = (state_q != ARB);
    assign bus.err_timeout = err_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed vector table plus packet sequences against a small UART model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int BW       = 20;
    localparam int BYTE_LEN = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .BAUD_WIDTH(BW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .BAUD_WIDTH(BW), .GAP_CYCLES(16), .BUSY_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic          v_valid [N];
    logic          v_last  [N];
    logic [7:0]    v_data  [N];
    logic [BW-1:0] v_baud  [N];
    int total = 0;
    int bad   = 0;

    always_comb begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.req_baud  = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]        = v_valid[i];
            bus.req_last[i]         = v_last[i];
            bus.req_data[8*i +: 8]  = v_data[i];
            bus.req_baud[BW*i +: BW] = v_baud[i];
        end
    end

    // UART model: tx_idle falls two cycles after tx_start, stays low BYTE_LEN cycles.
    logic m_d1, m_idle, stuck;
    int   m_cnt;
    assign bus.tx_idle = m_idle;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d1 <= 1'b0; m_idle <= 1'b1; m_cnt <= 0;
        end else begin
            m_d1 <= bus.tx_start;
            if (stuck) m_idle <= 1'b1;
            else if (m_d1) begin m_idle <= 1'b0; m_cnt <= BYTE_LEN; end
            else if (!m_idle) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt <= 1) m_idle <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    logic [N-1:0]  log_g [$];
    logic [7:0]    log_d [$];
    logic [BW-1:0] prev_baud;
    logic          prev_busy;

    always @(negedge clk) begin
        if (!rst && bus.tx_start) begin
            log_g.push_back(bus.grant);
            log_d.push_back(bus.tx_data);
            chk("ready_vs_grant", 32'(bus.req_ready), 32'(bus.grant));
        end
    end

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            prev_baud = '0; prev_busy = 1'b0;
        end else begin
            if (bus.baud_var !== prev_baud) chk("baud_change_outside_arb", 32'(prev_busy), 32'd0);
            prev_baud = bus.baud_var;
            prev_busy = bus.busy;
        end
    end

    function automatic bit cond(input int what);
        case (what)
            0:       return bus.tx_start;
            1:       return !bus.busy;
            2:       return !bus.tx_idle;
            3:       return bus.grant == '0;
            4:       return bus.err_timeout;
            default: return bus.req_ready[2];
        endcase
    endfunction

    task automatic wait_for(input int what, input string nm);
        int c = 0;
        while (!cond(what) && c < 600) begin @(negedge clk); c++; end
        if (!cond(what)) begin
            total++; bad++;
            $display("FAIL wait_%s: got timeout expected event", nm);
        end
    endtask

    task automatic wait_ready(input int r);
        int c = 0;
        do begin @(negedge clk); c++; end while (!bus.req_ready[r] && c < 3000);
        if (!bus.req_ready[r]) begin
            total++; bad++;
            $display("FAIL ready_%0d: got timeout expected pulse", r);
        end
    endtask

    task automatic send(input int r, input int n, input logic [7:0] b0, input logic [7:0] b1, input int stall);
        v_data[r] = b0; v_last[r] = (n == 1); v_valid[r] = 1'b1;
        wait_ready(r);
        if (n == 2) begin
            if (stall > 0) begin v_valid[r] = 1'b0; repeat (stall) @(negedge clk); end
            v_data[r] = b1; v_last[r] = 1'b1; v_valid[r] = 1'b1;
            wait_ready(r);
        end
        v_valid[r] = 1'b0; v_last[r] = 1'b0;
    endtask

    task automatic check_log(input string nm, input int n, input logic [3:0] eg [10], input logic [7:0] ed [10]);
        chk({nm, "_len"}, 32'(log_g.size()), 32'(n));
        for (int i = 0; i < n && i < log_g.size(); i++) begin
            chk($sformatf("%s_owner%0d", nm, i), 32'(log_g[i]), 32'(eg[i]));
            chk($sformatf("%s_data%0d", nm, i), 32'(log_d[i]), 32'(ed[i]));
        end
        log_g.delete(); log_d.delete();
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < N; i++) begin v_valid[i] = 1'b0; v_last[i] = 1'b0; end
        @(negedge clk); @(negedge clk); rst = 1'b0;
        log_g.delete(); log_d.delete();
    endtask

    typedef struct {
        logic [3:0]    mask;
        logic [3:0]    exp_grant;
        logic [7:0]    exp_data;
        logic [BW-1:0] exp_baud;
    } vec_t;
    vec_t tv [10];

    initial begin
        logic [3:0] eg [10];
        logic [7:0] ed [10];
        int n;
        stuck = 1'b0;
        for (int i = 0; i < N; i++) begin v_valid[i] = 0; v_last[i] = 0; v_data[i] = 0; end
        v_baud[0] = 20'd9600; v_baud[1] = 20'd115200; v_baud[2] = 20'd57600; v_baud[3] = 20'd19200;
        tv[0] = '{4'b0001, 4'b0001, 8'h10, 20'd9600};
        tv[1] = '{4'b1111, 4'b0010, 8'h21, 20'd115200};
        tv[2] = '{4'b1111, 4'b0100, 8'h32, 20'd57600};
        tv[3] = '{4'b1111, 4'b1000, 8'h43, 20'd19200};
        tv[4] = '{4'b1111, 4'b0001, 8'h50, 20'd9600};
        tv[5] = '{4'b1001, 4'b1000, 8'h63, 20'd19200};
        tv[6] = '{4'b0110, 4'b0010, 8'h71, 20'd115200};
        tv[7] = '{4'b0011, 4'b0001, 8'h80, 20'd9600};
        tv[8] = '{4'b0100, 4'b0100, 8'h92, 20'd57600};
        tv[9] = '{4'b0001, 4'b0001, 8'hA0, 20'd9600};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 0);   chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_start", 32'(bus.tx_start), 0); chk("rst_data", 32'(bus.tx_data), 0);
        chk("rst_baud", 32'(bus.baud_var), 0);  chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err", 32'(bus.err_timeout), 0);
        rst = 1'b0;
        @(negedge clk); chk("idle_grant", 32'(bus.grant), 0);

        // Single-byte packets, one per table row
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < N; i++) begin
                v_valid[i] = tv[v].mask[i]; v_last[i] = 1'b1; v_data[i] = {4'(v + 1), 4'(i)};
            end
            wait_for(0, "tv_start");
            chk($sformatf("tv%0d_grant", v), 32'(bus.grant), 32'(tv[v].exp_grant));
            chk($sformatf("tv%0d_data", v), 32'(bus.tx_data), 32'(tv[v].exp_data));
            chk($sformatf("tv%0d_baud", v), 32'(bus.baud_var), 32'(tv[v].exp_baud));
            chk($sformatf("tv%0d_ready", v), 32'(bus.req_ready), 32'(tv[v].exp_grant));
            for (int i = 0; i < N; i++) v_valid[i] = 1'b0;
            wait_for(1, "tv_done");
        end
        log_g.delete(); log_d.delete();

        // Two-byte packet from requester 0 and the post-packet gap
        v_baud[0] = 20'd115200;
        fork
            send(0, 2, 8'h55, 8'hA3, 0);
            begin
                wait_for(0, "a_start0");
                chk("a_data0", 32'(bus.tx_data), 32'h55); chk("a_baud0", 32'(bus.baud_var), 115200);
                @(negedge clk); wait_for(0, "a_start1");
                chk("a_data1", 32'(bus.tx_data), 32'hA3); chk("a_grant1", 32'(bus.grant), 32'b0001);
                wait_for(3, "a_gap");
                n = 0;
                while (bus.busy && n < 100) begin n++; @(negedge clk); end
                chk("a_gap_len", 32'(n), 16); chk("a_baud_end", 32'(bus.baud_var), 115200);
            end
        join
        log_g.delete(); log_d.delete();

        // All requesters busy: fair rotation, packets stay contiguous
        do_reset();
        fork
            begin send(0, 2, 8'h01, 8'h02, 0); send(0, 1, 8'h03, 8'h00, 0); end
            send(1, 2, 8'h11, 8'h12, 0);
            send(2, 2, 8'h21, 8'h22, 0);
            send(3, 2, 8'h31, 8'h32, 0);
        join
        wait_for(1, "b_done");
        eg = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0000};
        ed = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h03, 8'h00};
        check_log("rot", 9, eg, ed);

        // Owner 2 stalls mid-packet; requester 3 must wait
        do_reset();
        fork
            send(2, 2, 8'hC1, 8'hC2, 50);
            send(3, 1, 8'hD1, 8'h00, 0);
            begin
                wait_for(5, "c_ready");
                n = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (bus.grant != 4'b0100 || bus.tx_start) n++;
                end
                chk("c_stall_lock", 32'(n), 0);
            end
        join
        wait_for(1, "c_done");
        eg = '{4'b0100, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ed = '{8'hC1, 8'hC2, 8'hD1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_log("stall", 3, eg, ed);

        // Busy timeout on requester 1
        stuck = 1'b1;
        fork
            send(1, 1, 8'h5A, 8'h00, 0);
            begin
                wait_for(0, "d_start");
                n = 0;
                do begin @(negedge clk); n++; end while (!bus.err_timeout && n < 40);
                chk("d_timeout_lat", 32'(n), 15); chk("d_grant", 32'(bus.grant), 0);
                stuck = 1'b0;
                @(negedge clk); chk("d_err_pulse", 32'(bus.err_timeout), 0);
            end
        join
        wait_for(1, "d_gap");
        log_g.delete(); log_d.delete();
        fork
            send(0, 1, 8'hE0, 8'h00, 0);
            send(1, 1, 8'hE1, 8'h00, 0);
            send(2, 1, 8'hE2, 8'h00, 0);
        join
        wait_for(1, "d_done");
        eg = '{4'b0100, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ed = '{8'hE2, 8'hE0, 8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_log("after_to", 3, eg, ed);

        // Asynchronous reset while a 3-byte packet waits for the UART
        v_data[1] = 8'h71; v_last[1] = 1'b0; v_valid[1] = 1'b1;
        wait_for(0, "e_start");
        v_data[1] = 8'h72;
        wait_for(2, "e_busy");
        #2 rst = 1'b1;
        v_valid[1] = 1'b0;
        #1;
        chk("e_grant", 32'(bus.grant), 0);   chk("e_ready", 32'(bus.req_ready), 0);
        chk("e_start", 32'(bus.tx_start), 0); chk("e_data", 32'(bus.tx_data), 0);
        chk("e_baud", 32'(bus.baud_var), 0);  chk("e_busy", 32'(bus.busy), 0);
        chk("e_err", 32'(bus.err_timeout), 0);
        @(negedge clk); rst = 1'b0;
        v_data[1] = 8'h7E; v_last[1] = 1'b1; v_valid[1] = 1'b1;
        v_data[3] = 8'h3E; v_last[3] = 1'b1; v_valid[3] = 1'b1;
        wait_for(0, "e_post0");
        chk("e_post_grant", 32'(bus.grant), 32'b0010); chk("e_post_data", 32'(bus.tx_data), 32'h7E);
        v_valid[1] = 1'b0;
        @(negedge clk); wait_for(0, "e_post1");
        chk("e_next_grant", 32'(bus.grant), 32'b1000);
        v_valid[3] = 1'b0;
        wait_for(1, "e_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one uart_var_tx instance between NUM_REQ byte-stream requesters. Each requester supplies bytes with valid/ready/last framing and its own baud divisor input. The arbiter locks the grant for a whole packet (until the last byte) and drives tx_start/tx_data/baud_var. It sequences each byte using only the transmitter's tx_idle status. It sits between the command/telemetry sources and the UART TX in the DDS control path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BAUD_WIDTH, 20, width of baud value, matches uart_var_tx baud_width
GAP_CYCLES, 16, idle clk cycles inserted after each packet before re-arbitration (lets baud change settle)
BUSY_TIMEOUT, 15, max cycles to wait for tx_idle to fall after a tx_start pulse

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
req_last  in  NUM_REQ  byte is last of packet
req_baud  in  BAUD_WIDTH*NUM_REQ  per-requester baud value
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
grant  out  NUM_REQ  one-hot current owner; 0 when no owner
tx_start  out  1  one-cycle start pulse to UART
tx_data  out  8  byte to UART; valid in the tx_start cycle
baud_var  out  BAUD_WIDTH  baud to UART; held for whole packet
tx_idle  in  1  UART idle status (registered inside UART)
busy  out  1  high whenever state is not ARB
err_timeout  out  1  one-cycle pulse on busy timeout

Behaviour:
- Reset values: req_ready=0, grant=0, tx_start=0, tx_data=0, baud_var=0, busy=0, err_timeout=0, rr pointer=0, state=ARB. Reset mid-packet aborts immediately. No byte is accepted in the reset cycle.
- States: ARB, START, WAIT_BUSY, WAIT_IDLE, GAP.
- ARB:
  - If any req_valid is set and tx_idle=1, pick the first valid requester at or after the rr pointer, wrapping.
  - Latch its req_baud into baud_var; set grant one-hot; go to START.
  - If nothing is valid, stay in ARB with grant=0.
- START:
  - If the granted req_valid=1: register tx_data=req_data, pulse tx_start=1 and req_ready[g]=1 for exactly one cycle, latch last_flag=req_last[g], clear the timeout counter, go to WAIT_BUSY.
  - If the granted req_valid=0: wait in START, grant held. The packet lock persists while a requester stalls mid-packet.
- WAIT_BUSY:
  - When tx_idle=0, go to WAIT_IDLE.
  - Otherwise count up; if the count reaches BUSY_TIMEOUT, pulse err_timeout, drop grant, advance the rr pointer past g, go to GAP.
  - Expected latency from the tx_start cycle to tx_idle falling is 2 cycles.
- WAIT_IDLE:
  - When tx_idle=1, go to GAP if last_flag=1, else go to START (same owner).
  - The next byte's tx_start issues no earlier than 1 cycle after tx_idle rises.
- GAP: grant=0; count GAP_CYCLES cycles, set the rr pointer to (g+1) mod NUM_REQ, go to ARB.
- Round-robin is updated only at packet end or timeout, never per byte.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0...
- baud_var changes only in ARB; it is stable from grant until GAP ends.
- req_valid of non-granted requesters is ignored. Their req_ready stays 0.
- Simultaneous requests in ARB are resolved purely by the rr pointer. A requester arriving during a packet waits until the next ARB.
- Single-byte packet (valid and last in the first byte) is legal.
- Data in the START acceptance cycle is sampled combinationally from the requester and registered. Requesters must hold data/last stable while valid is high until req_ready.

Decomposition:
- Package uart_arb_pkg holds the state encoding localparams (ARB..GAP) and the default BUSY_TIMEOUT/GAP_CYCLES constants.
- One natural sub-module: rr_arbiter (combinational first-valid-from-pointer select, NUM_REQ-parameterised, one-hot out plus index out).
- Counters stay inline.

Test Plan:
- Single requester 0, packet 0x55,0xA3(last), baud 115200 -> two tx_start pulses, tx_data 0x55 then 0xA3, baud_var=115200 throughout, req_ready pulses align with tx_start, grant=0 after GAP_CYCLES=16.
- All four valid, 2-byte packets each -> grant order 0,1,2,3,0; no interleaving of bytes between owners; each owner's packet completes contiguously.
- Req0 at 9600 and req1 at 115200 back-to-back -> baud_var switches only during ARB after ≥16 idle cycles; UART model decodes both packets at correct rates.
- Requester 2 drops req_valid for 50 cycles mid-packet -> grant stays 0b0100, no tx_start, requester 3 (valid) not served until req2 sends last.
- UART model holds tx_idle=1 after tx_start -> err_timeout pulses 15 cycles after tx_start, grant clears, next ARB picks requester after the failed one.
- rst asserted during WAIT_IDLE of a 3-byte packet -> all outputs return to reset values same cycle, rr pointer=0, first post-reset grant goes to the lowest valid index.
